// File: rtl/plab4_net_router_out_sched.sv
// Output-port scheduler for the 3-input ring router.
// Round-robin arbitration among west/terminal/east queues, credit-based flow
// control toward the downstream input queue, and bubble flow control for the
// injection (terminal) requester so the ring cannot deadlock.
module plab4_net_router_out_sched #(
  parameter int p_num_credits = 4,
  parameter int p_inject_idx  = 1,
  parameter bit p_bubble_en   = 1'b1,
  localparam int c_cnt_nbits  = $clog2(p_num_credits + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             reqs,
  output logic [2:0]             grants,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [1:0]             xbar_sel,
  input  logic                   credit_ret,
  output logic [c_cnt_nbits-1:0] credits,
  output logic                   credit_err
);

  localparam logic [c_cnt_nbits-1:0] c_max = c_cnt_nbits'(p_num_credits);
  localparam logic [c_cnt_nbits-1:0] c_one = c_cnt_nbits'(1);

  // Architectural state
  logic [2:0]             ptr_q,      ptr_d;
  logic [c_cnt_nbits-1:0] credits_q,  credits_d;
  logic                   lock_q,     lock_d;
  logic [1:0]             lock_idx_q, lock_idx_d;
  logic                   err_q,      err_d;

  // Combinational arbitration signals
  logic [2:0] elig;
  logic [2:0] mask_hi;
  logic [2:0] elig_hi;
  logic [2:0] rr_pick;
  logic [2:0] chosen;
  logic [1:0] chosen_idx;
  logic       fire;

  // A requester is eligible only if enough downstream slots are free; the
  // injection requester needs two when bubble flow control is enabled.
  for (genvar gi = 0; gi < 3; gi++) begin : g_elig
    localparam int c_need = ((gi == p_inject_idx) && p_bubble_en) ? 2 : 1;
    assign elig[gi] = reqs[gi] && (int'(credits_q) >= c_need);
  end

  // Round-robin: first eligible at or above the pointer, else wrap to the
  // lowest eligible. ptr_q is one-hot, so ~(ptr_q - 1) masks positions >= ptr.
  assign mask_hi = ~(ptr_q - 3'd1);
  assign elig_hi = elig & mask_hi;
  assign rr_pick = (|elig_hi) ? (elig_hi & (~elig_hi + 3'd1))
                              : (elig & (~elig + 3'd1));

  // A stalled packet keeps the link until it transfers; if its request has
  // vanished, fall back to normal arbitration so the port recovers.
  always_comb begin
    chosen = rr_pick;
    if (lock_q && elig[lock_idx_q]) begin
      chosen = 3'b001 << lock_idx_q;
    end
  end

  // One-hot to index encoding for the crossbar select.
  always_comb begin
    chosen_idx = 2'd0;
    if (chosen[1]) chosen_idx = 2'd1;
    if (chosen[2]) chosen_idx = 2'd2;
  end

  assign out_val    = |chosen;
  assign xbar_sel   = chosen_idx;
  assign grants     = chosen & {3{out_rdy}};
  assign fire       = out_val && out_rdy;
  assign credits    = credits_q;
  assign credit_err = err_q;

  // Next-state for lock, priority pointer, credit counter and error flag.
  always_comb begin
    lock_d     = out_val && !out_rdy;
    lock_idx_d = chosen_idx;
    ptr_d      = ptr_q;
    credits_d  = credits_q;
    err_d      = err_q;
    if (fire) begin
      ptr_d = {chosen[1:0], chosen[2]};
    end
    if (fire && !credit_ret) begin
      if (credits_q == '0) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q - c_one;
      end
    end else if (!fire && credit_ret) begin
      if (credits_q == c_max) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q + c_one;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= 3'b001;
      credits_q  <= c_max;
      lock_q     <= 1'b0;
      lock_idx_q <= 2'd0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      credits_q  <= credits_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
    end
  end

endmodule
